// File: rtl/voice_allocator_pkg.sv
// Shared constants for the voice allocator: rest code, default widths, voice-count ceiling.
package voice_allocator_pkg;
    localparam int NOTE_REST  = 0;
    localparam int NOTE_W_DEF = 6;
    localparam int DUR_W_DEF  = 6;
    localparam int MAX_VOICES = 8;
endpackage

// File: rtl/voice_allocator_if.sv
// Note offer channel from the song reader: valid/ready with note code and beat duration.
interface voice_allocator_if
    import voice_allocator_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int DUR_W  = DUR_W_DEF
);
    logic              note_valid;
    logic              note_ready;
    logic [NOTE_W-1:0] note_in;
    logic [DUR_W-1:0]  dur_in;

    modport master (output note_valid, output note_in, output dur_in, input note_ready);
    modport slave  (input note_valid, input note_in, input dur_in, output note_ready);
endinterface

// File: rtl/voice_allocator_voice_slot.sv
// One voice slot: note register, beat countdown and active flag; load wins over tick, clear wins over both.
// Latency 1 from load to note/active/load_pulse; no backpressure of its own.
module voice_slot
    import voice_allocator_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int DUR_W  = DUR_W_DEF
) (
    input  logic              clk,
    input  logic              r_n,
    input  logic              load,
    input  logic              tick,
    input  logic              clear,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [DUR_W-1:0]  dur_in,
    output logic [NOTE_W-1:0] note,
    output logic              active,
    output logic              load_pulse
);
    logic [DUR_W-1:0] remaining;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            note       <= NOTE_W'(NOTE_REST);
            remaining  <= '0;
            active     <= 1'b0;
            load_pulse <= 1'b0;
        end else if (clear) begin
            note       <= NOTE_W'(NOTE_REST);
            remaining  <= '0;
            active     <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= load;
            if (load) begin
                note      <= note_in;
                remaining <= dur_in;
                active    <= 1'b1;
            end else if (tick && active) begin
                // Last beat releases the slot and silences it in the same edge.
                if (remaining > DUR_W'(1)) begin
                    remaining <= remaining - DUR_W'(1);
                end else begin
                    remaining <= '0;
                    active    <= 1'b0;
                    note      <= NOTE_W'(NOTE_REST);
                end
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: places each accepted note in the lowest free slot, 1-cycle load latency.
// Backpressure: note_ready drops when all slots are busy, paused, flushing or in reset.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = NOTE_W_DEF,
    parameter int DUR_W      = DUR_W_DEF
) (
    input  logic                         clk,
    input  logic                         r_n,
    input  logic                         play,
    input  logic                         flush,
    input  logic                         beat,
    voice_allocator_if.slave             nif,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         all_idle
);
    localparam logic [NUM_VOICES-1:0] LSB_ONE = NUM_VOICES'(1);

    logic                  note_ready;
    logic                  accept;
    logic                  tick;
    logic [NUM_VOICES-1:0] free_vec;
    logic [NUM_VOICES-1:0] pick;
    logic [NUM_VOICES-1:0] slot_load;

    // Selection uses registered activity, so a slot freed this edge is only offered next cycle.
    assign free_vec   = ~voice_active;
    assign pick       = free_vec & (~free_vec + LSB_ONE);

    assign note_ready = r_n & play & ~flush & ~(&voice_active);
    assign accept     = nif.note_valid & note_ready & (nif.dur_in != '0);
    assign slot_load  = {NUM_VOICES{accept}} & pick;
    assign tick       = play & beat & ~flush;

    assign nif.note_ready = note_ready;
    assign all_idle       = ~|voice_active;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W)
        ) u_slot (
            .clk        (clk),
            .r_n        (r_n),
            .load       (slot_load[g]),
            .tick       (tick),
            .clear      (flush),
            .note_in    (nif.note_in),
            .dur_in     (nif.dur_in),
            .note       (voice_note[g*NOTE_W +: NOTE_W]),
            .active     (voice_active[g]),
            .load_pulse (voice_load[g])
        );
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a slot model.
module tb_voice_allocator;
    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;

    logic            clk = 1'b0;
    logic            r_n;
    logic            play;
    logic            flush;
    logic            beat;
    logic [NV-1:0]    voice_load;
    logic [NV*NW-1:0] voice_note;
    logic [NV-1:0]    voice_active;
    logic             all_idle;

    voice_allocator_if #(.NOTE_W(NW), .DUR_W(DW)) nif ();

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk          (clk),
        .r_n          (r_n),
        .play         (play),
        .flush        (flush),
        .beat         (beat),
        .nif          (nif),
        .voice_load   (voice_load),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .all_idle     (all_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-slot note, beats left and busy flag.
    int          m_rem  [NV];
    logic [NW-1:0] m_note [NV];
    bit          m_act  [NV];
    logic [NV-1:0] m_load;

    function automatic void m_clear();
        for (int i = 0; i < NV; i++) begin
            m_rem[i]  = 0;
            m_note[i] = '0;
            m_act[i]  = 1'b0;
        end
        m_load = '0;
    endfunction

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < NV; i++) if (!m_act[i]) f = 1'b0;
        return f;
    endfunction

    function automatic bit m_ready();
        return (r_n === 1'b1) && play && !flush && !m_full();
    endfunction

    initial m_clear();
    always @(negedge r_n) m_clear();

    always @(posedge clk) begin
        bit acc;
        int tgt;
        if (r_n === 1'b1) begin
            acc    = nif.note_valid && m_ready();
            tgt    = -1;
            m_load = '0;
            if (flush) begin
                m_clear();
            end else begin
                if (acc && nif.dur_in != 0) begin
                    for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) tgt = i;
                end
                for (int i = 0; i < NV; i++) begin
                    if (i == tgt) begin
                        m_note[i] = nif.note_in;
                        m_rem[i]  = int'(nif.dur_in);
                        m_act[i]  = 1'b1;
                        m_load[i] = 1'b1;
                    end else if (play && beat && m_act[i]) begin
                        m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) begin
                            m_act[i]  = 1'b0;
                            m_note[i] = '0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NV-1:0] exp_act;
        for (int i = 0; i < NV; i++) begin
            exp_act[i] = m_act[i];
            chk("model_note", voice_note[i*NW +: NW], m_note[i]);
        end
        chk("model_load",   voice_load,     m_load);
        chk("model_active", voice_active,   exp_act);
        chk("model_idle",   all_idle,       ~|exp_act);
        chk("model_ready",  nif.note_ready, m_ready());
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat1();
        beat = 1'b1;
        cyc();
        beat = 1'b0;
    endtask

    initial begin
        r_n = 1'b0; play = 1'b1; flush = 1'b0; beat = 1'b0;
        nif.note_valid = 1'b0; nif.note_in = '0; nif.dur_in = '0;
        #1;
        chk("rst_idle",   all_idle,       1);
        chk("rst_ready",  nif.note_ready, 0);
        chk("rst_active", voice_active,   0);
        cyc(); cyc();
        r_n = 1'b1;
        cyc();
        chk("post_rst_ready", nif.note_ready, 1);

        // Single note, duration 3
        nif.note_valid = 1'b1; nif.note_in = 6'd12; nif.dur_in = 6'd3;
        cyc();
        nif.note_valid = 1'b0;
        chk("t1_load",   voice_load,      3'b001);
        chk("t1_note0",  voice_note[5:0], 12);
        chk("t1_active", voice_active,    3'b001);
        cyc();
        chk("t1_load_off", voice_load, 0);
        beat1(); cyc(); beat1(); cyc();
        chk("t1_active_b2", voice_active, 3'b001);
        beat1();
        chk("t1_active_b3", voice_active,    0);
        chk("t1_note0_b3",  voice_note[5:0], 0);
        chk("t1_idle_b3",   all_idle,        1);

        // Four notes into three slots, the fourth waits
        nif.note_valid = 1'b1; nif.dur_in = 6'd5; nif.note_in = 6'd20;
        cyc(); chk("t2_load0", voice_load, 3'b001);
        nif.note_in = 6'd21;
        cyc(); chk("t2_load1", voice_load, 3'b010);
        nif.note_in = 6'd22;
        cyc(); chk("t2_load2", voice_load, 3'b100);
        chk("t2_ready_full", nif.note_ready, 0);
        nif.note_in = 6'd23;
        cyc();
        chk("t2_held_load", voice_load,   0);
        chk("t2_full",      voice_active, 3'b111);
        repeat (4) begin beat1(); cyc(); end
        chk("t2_full_b4", voice_active, 3'b111);
        beat1();
        chk("t2_free_b5", voice_active, 0);
        cyc();
        chk("t2_load4", voice_load,      3'b001);
        chk("t2_note4", voice_note[5:0], 23);
        nif.note_valid = 1'b0;
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("flush_clear", voice_active, 0);

        // Slot 1 expires on the cycle a note is offered
        nif.note_valid = 1'b1; nif.note_in = 6'd1; nif.dur_in = 6'd4; cyc();
        nif.note_in = 6'd2; nif.dur_in = 6'd1; cyc();
        nif.note_in = 6'd3; nif.dur_in = 6'd4; cyc();
        nif.note_in = 6'd9; nif.dur_in = 6'd6; beat = 1'b1;
        #1;
        chk("t3_ready_full", nif.note_ready, 0);
        cyc(); beat = 1'b0;
        chk("t3_freed",   voice_active,   3'b101);
        chk("t3_noload",  voice_load,     0);
        chk("t3_ready",   nif.note_ready, 1);
        cyc(); nif.note_valid = 1'b0;
        chk("t3_load1",   voice_load,       3'b010);
        chk("t3_note1",   voice_note[11:6], 9);
        chk("t3_active",  voice_active,     3'b111);
        repeat (2) begin beat1(); cyc(); end
        chk("t3_b2", voice_active, 3'b111);
        beat1();
        chk("t3_b3", voice_active, 3'b010);
        cyc();
        repeat (2) begin beat1(); cyc(); end
        chk("t3_b5", voice_active, 3'b010);
        beat1();
        chk("t3_b6", voice_active, 0);

        // Zero duration: accepted and dropped
        nif.note_valid = 1'b1; nif.note_in = 6'd7; nif.dur_in = 6'd0;
        #1;
        chk("t4_ready", nif.note_ready, 1);
        cyc(); nif.note_valid = 1'b0;
        chk("t4_noload", voice_load,   0);
        chk("t4_active", voice_active, 0);

        // Pause across beats
        nif.note_valid = 1'b1; nif.note_in = 6'd4; nif.dur_in = 6'd3; cyc();
        nif.note_in = 6'd5; nif.dur_in = 6'd5; cyc();
        chk("t5_active", voice_active, 3'b011);
        play = 1'b0; nif.note_in = 6'd30; nif.dur_in = 6'd2;
        repeat (4) begin
            beat1();
            chk("t5_paused_ready", nif.note_ready, 0);
            chk("t5_paused_load",  voice_load,     0);
            cyc();
        end
        chk("t5_paused_active", voice_active, 3'b011);
        play = 1'b1; nif.note_valid = 1'b0; cyc();
        repeat (2) begin beat1(); cyc(); end
        chk("t5_b2", voice_active, 3'b011);
        beat1();
        chk("t5_b3", voice_active, 3'b010);
        cyc(); beat1(); cyc();
        chk("t5_b4", voice_active, 3'b010);
        beat1();
        chk("t5_b5", voice_active, 0);

        // Flush beats a pending offer, then async reset mid-countdown
        nif.note_valid = 1'b1; nif.note_in = 6'd8; nif.dur_in = 6'd5; cyc();
        nif.note_in = 6'd9; cyc();
        chk("t6_active", voice_active, 3'b011);
        nif.note_in = 6'd11; nif.dur_in = 6'd4; flush = 1'b1;
        cyc(); flush = 1'b0; nif.note_valid = 1'b0;
        chk("t6_flush_active", voice_active, 0);
        chk("t6_flush_load",   voice_load,   0);
        nif.note_valid = 1'b1; nif.note_in = 6'd13; nif.dur_in = 6'd6; cyc();
        nif.note_in = 6'd14; cyc();
        nif.note_valid = 1'b0;
        beat1();
        r_n = 1'b0;
        #1;
        chk("t6_arst_active", voice_active,   0);
        chk("t6_arst_note",   voice_note,     0);
        chk("t6_arst_idle",   all_idle,       1);
        chk("t6_arst_ready",  nif.note_ready, 0);
        cyc(); r_n = 1'b1; cyc();

        // Randomized traffic
        repeat (3000) begin
            r_n            = ($urandom_range(0, 499) != 0);
            play           = ($urandom_range(0, 9) != 0);
            flush          = ($urandom_range(0, 39) == 0);
            beat           = ($urandom_range(0, 3) == 0);
            nif.note_valid = ($urandom_range(0, 4) < 3);
            nif.note_in    = NW'($urandom_range(0, 63));
            nif.dur_in     = DW'($urandom_range(0, 9));
            cyc();
        end
        r_n = 1'b1; play = 1'b1; flush = 1'b0; beat = 1'b0; nif.note_valid = 1'b0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Schedules up to NUM_VOICES simultaneous notes onto a bank of voice slots for polyphonic playback. Sits between the song reader and the per-voice note players. Accepts notes over a valid/ready handshake, assigns each note to the lowest-index free slot, and counts down its duration on beat pulses. Frees the slot when the duration expires and back-pressures the song reader when every slot is busy.

Parameters:
NUM_VOICES, 3, number of voice slots (1..8)
NOTE_W, 6, note code width; code 0 = rest/silence
DUR_W, 6, duration width in beats

Ports:
clk  input  1  system clock
r_n  input  1  asynchronous active-low reset
play  input  1  1 = run; 0 = pause (counters frozen, no accepts)
flush  input  1  synchronous clear of all voices
beat  input  1  one-cycle beat pulse
note_valid  input  1  song reader offers a note
note_in  input  NOTE_W  offered note code
dur_in  input  DUR_W  offered duration in beats
note_ready  output  1  allocator can accept this cycle
voice_load  output  NUM_VOICES  one-hot, one-cycle pulse: slot i loaded a new note
voice_note  output  NUM_VOICES*NOTE_W  current note per slot; slot i at [i*NOTE_W +: NOTE_W]
voice_active  output  NUM_VOICES  slot i is holding a sounding note
all_idle  output  1  no slot active

Behaviour:
- Reset: async on r_n low. All state clears immediately: voice_note=0, voice_active=0, voice_load=0, remaining counters=0. all_idle=1 and note_ready=0 while r_n is low. Release is synchronous to clk.
- note_ready = play & ~flush & ~(&voice_active). It is combinational from registered state only and never depends on note_valid.
- Accept occurs on a cycle with note_valid & note_ready.
  - Target slot is the lowest index i with voice_active[i]=0.
  - Latency is 1. On the next edge: voice_note[i]<=note_in, remaining[i]<=dur_in, voice_active[i]<=1, voice_load[i]<=1 for exactly one cycle.
  - dur_in==0: the note is accepted and discarded. No slot changes and no voice_load pulse.
  - note_in==0 with dur_in>0 is a valid rest. It occupies a slot for its duration.
- Beat countdown, applied when play & beat & ~flush, for each active slot not being loaded this cycle:
  - remaining>1: decrement by 1.
  - remaining==1: remaining<=0, voice_active<=0, voice_note<=0.
- Simultaneous events:
  - A slot freed by a beat is not allocatable until the following cycle, because ready and selection use registered voice_active.
  - A slot loaded on a beat cycle takes the full dur_in with no decrement.
- play=0: no accepts, beats ignored, all outputs hold. voice_load is 0.
- flush: takes priority over accept and beat. On the next edge all slots clear as in reset, voice_load=0. The song reader must re-offer any note not accepted.
- all_idle = ~|voice_active, combinational.
- voice_load is registered and is 0 in every cycle not following an accept.
- Counter arithmetic is unsigned DUR_W-bit. No wrap is possible because decrement occurs only when remaining≥1.

Decomposition:
- Shared package holds:
  - NOTE_REST = 0
  - default widths NOTE_W=6 and DUR_W=6
  - maximum NUM_VOICES=8
- Natural sub-module: voice_slot, instantiated NUM_VOICES times.
  - Inputs: load, tick, clear, note_in, dur_in.
  - Outputs: note, active, load_pulse.
  - Holds the note register, remaining counter and active flag.
- The top level contains the lowest-free priority encoder, the ready logic and the output concatenation.

Test Plan:
- Reset then play=1, offer note 6'd12/dur 3 → voice_load=3'b001 the next cycle, voice_note[0]=12, active=001. After 3 beats, active=000 and note[0]=0 on the edge of the 3rd beat.
- Offer 4 notes back-to-back with dur 5, NUM_VOICES=3 → slots 0,1,2 load on consecutive cycles. note_ready=0 after the third accept and the 4th note is held, not dropped. After 5 beats all free and the 4th note loads into slot 0.
- Slot 1 expires on the same cycle a note is offered while slots 0 and 2 are busy → note_ready=0 that cycle. The note loads into slot 1 on the next cycle with its full duration.
- Offer dur_in=0, note 7 → handshake completes, no voice_load pulse, active unchanged.
- Two slots active, play=0 for 4 beats then play=1 → remaining counts unchanged across the paused beats, note_ready=0 while paused.
- Assert flush with note_valid=1 and 2 active slots → next cycle active=000, no load. Then assert r_n=0 mid-countdown → outputs clear immediately without a clock edge.
